keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad and encodes one debounced key press into a 4-bit hex code (key -> hex).

---
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with 2-flop row sync, press/release
// debounce and key-to-hex encoding; one-cycle key_valid strobe per accepted press.
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4800,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_CYCLES + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   deb_q, deb_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic [1:0]      low_row;
  logic            row_level;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Rows are asynchronous to clk; only the second flop feeds the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= rows;
      sync2_q <= sync1_q;
    end
  end

  // Lowest-index low row wins when several rows are pulled low together.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!sync2_q[i]) low_row = 2'(i);
    end
  end

  assign row_level = sync2_q[row_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      dwell_q <= '0;
      deb_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    deb_d   = deb_q;
    code_d  = code_q;
    valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        // Rows are sampled only on the last dwell cycle so the column can settle.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (sync2_q != 4'hF) begin
            state_d = DEB_PRESS;
            row_d   = low_row;
            deb_d   = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEB_PRESS: begin
        if (row_level) begin
          state_d = SCAN;
          dwell_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          code_d  = key_map(row_q, col_q);
          valid_d = 1'b1;
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
      HELD: begin
        if (row_level) begin
          state_d = DEB_RELEASE;
          deb_d   = '0;
        end
      end
      default: begin
        if (!row_level) begin
          state_d = HELD;
        end else if (deb_q == DEB_LAST) begin
          state_d = SCAN;
          dwell_d = '0;
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
    endcase
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD) || (state_q == DEB_RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad stimulus with a key-matrix model; expected
// key codes are queued at press time and matched by a monitor on each key_valid.
`default_nettype none

module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c set while key at row r, column c is down
  logic [3:0]  exp_q[$];
  int          checks;
  int          errors;

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic press(input int r, input int c, input logic v);
    pressed[r*4+c] = v;
  endtask

  task automatic wait_cols(input logic [3:0] target, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (cols === target) found = 1'b1;
      else tick(1);
    end
    if (!found) chk({name, "_timeout"}, {28'd0, cols}, {28'd0, target});
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0) done = 1'b1;
      else tick(1);
    end
    if (!done) chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=%0h expected=none", key_code);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e) begin
            errors++;
            $display("FAIL pulse_code actual=%0h expected=%0h", key_code, e);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    pressed = 16'h0;
    reset   = 1'b1;
    fork
      monitor();
    join_none

    // 1. Reset state and idle scan rotation
    tick(3);
    reset = 1'b0;
    chk("rst_cols", {28'd0, cols}, 32'hE);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    tick(3);
    chk("scan_c0_end", {28'd0, cols}, 32'hE);
    tick(1);
    chk("scan_c1", {28'd0, cols}, 32'hD);
    tick(11);
    chk("scan_c3", {28'd0, cols}, 32'h7);
    tick(1);
    chk("scan_wrap", {28'd0, cols}, 32'hE);

    // 2. Press '5' for 60 cycles
    exp_q.push_back(4'h5);
    press(1, 1, 1'b1);
    tick(30);
    chk("k5_held", {31'd0, key_held}, 32'd1);
    chk("k5_cols", {28'd0, cols}, 32'hD);
    chk("k5_code", {28'd0, key_code}, 32'h5);
    tick(30);
    press(1, 1, 1'b0);
    tick(10);
    chk("k5_rel_held", {31'd0, key_held}, 32'd1);
    chk("k5_rel_cols", {28'd0, cols}, 32'hD);
    tick(1);
    chk("k5_rel_done", {31'd0, key_held}, 32'd0);
    chk("k5_rel_col1", {28'd0, cols}, 32'hD);

    // 3. Press bounce on '5'
    wait_cols(4'hE, "pb_c0");
    wait_cols(4'hD, "pb_c1");
    press(1, 1, 1'b1);
    tick(4);
    press(1, 1, 1'b0);
    tick(1);
    chk("pb_held", {31'd0, key_held}, 32'd0);
    tick(5);
    chk("pb_resume_c1", {28'd0, cols}, 32'hD);
    tick(1);
    chk("pb_next_c2", {28'd0, cols}, 32'hB);
    chk("pb_code", {28'd0, key_code}, 32'h5);

    // 4. Release bounce while held on '5'
    wait_cols(4'hE, "rb_c0");
    wait_cols(4'hD, "rb_c1");
    exp_q.push_back(4'h5);
    press(1, 1, 1'b1);
    tick(20);
    chk("rb_held0", {31'd0, key_held}, 32'd1);
    press(1, 1, 1'b0);
    tick(3);
    press(1, 1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("rb_held", {31'd0, key_held}, 32'd1);
    end
    press(1, 1, 1'b0);
    tick(12);
    chk("rb_released", {31'd0, key_held}, 32'd0);

    // 5. Hold '0', press '9', release '0'
    wait_cols(4'hE, "tk_c0");
    wait_cols(4'hD, "tk_c1");
    exp_q.push_back(4'h0);
    press(3, 1, 1'b1);
    tick(20);
    chk("tk_code0", {28'd0, key_code}, 32'h0);
    chk("tk_held0", {31'd0, key_held}, 32'd1);
    press(2, 2, 1'b1);
    tick(30);
    chk("tk_frozen", {28'd0, cols}, 32'hD);
    chk("tk_no9", {28'd0, key_code}, 32'h0);
    exp_q.push_back(4'h9);
    press(3, 1, 1'b0);
    wait_drain(80, "tk_9");
    chk("tk_code9", {28'd0, key_code}, 32'h9);
    chk("tk_held9", {31'd0, key_held}, 32'd1);
    press(2, 2, 1'b0);
    tick(15);
    chk("tk_rel9", {31'd0, key_held}, 32'd0);

    // Row priority: '1' (row0) and 'E' (row3) together in column 0
    wait_cols(4'hE, "pr_c0");
    exp_q.push_back(4'h1);
    press(0, 0, 1'b1);
    press(3, 0, 1'b1);
    tick(20);
    chk("pr_code", {28'd0, key_code}, 32'h1);
    press(0, 0, 1'b0);
    press(3, 0, 1'b0);
    tick(12);
    chk("pr_rel", {31'd0, key_held}, 32'd0);

    // 6. Reset at debounce count 5
    wait_cols(4'h7, "rs_c3");
    wait_cols(4'hE, "rs_c0");
    press(0, 0, 1'b1);
    tick(9);
    reset = 1'b1;
    tick(1);
    chk("rs_cols", {28'd0, cols}, 32'hE);
    chk("rs_valid", {31'd0, key_valid}, 32'd0);
    chk("rs_code", {28'd0, key_code}, 32'h0);
    chk("rs_held", {31'd0, key_held}, 32'd0);
    press(0, 0, 1'b0);
    reset = 1'b0;
    tick(20);
    chk("rs_code_after", {28'd0, key_code}, 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
